// File: rtl/sin_pkg.sv
// Shared definitions for the sine DDS sequencer: FSM encoding, quadrant codes
// and the helpers that locate the table index field inside the phase word.
package sin_pkg;

    // Sequencer states; one table read per pass through StIssue.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIssue   = 2'd1,
        StCapture = 2'd2,
        StPresent = 2'd3
    } dds_state_e;

    // Quadrant codes taken from the two phase MSBs.
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // Default geometry, matching the sin_table defaults.
    localparam int unsigned DefDataWidth  = 8;
    localparam int unsigned DefAddrWidth  = 8;
    localparam int unsigned DefPhaseWidth = 24;

    // Index field position for the default geometry.
    localparam int unsigned IdxMsb = DefPhaseWidth - 3;
    localparam int unsigned IdxLsb = DefPhaseWidth - 2 - DefAddrWidth;

    // Index MSB sits just below the two quadrant bits.
    function automatic int unsigned idx_msb(input int unsigned phase_width);
        return phase_width - 3;
    endfunction

    // Index LSB; everything below it is fractional phase.
    function automatic int unsigned idx_lsb(input int unsigned phase_width,
                                            input int unsigned addr_width);
        return phase_width - 2 - addr_width;
    endfunction

endpackage

// File: rtl/sin_quad_fold.sv
// Quarter-wave folding: maps a phase word to a quarter-wave table address and
// a negate flag. Purely combinational; only used in the full-wave build.
module sin_quad_fold
    import sin_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH = DefPhaseWidth,
    parameter int unsigned ADDR_WIDTH  = DefAddrWidth
) (
    input  logic [PHASE_WIDTH-1:0] phase_i,
    output logic [ADDR_WIDTH-1:0]  addr_o,
    output logic                   negate_o
);

    localparam int unsigned Msb = idx_msb(PHASE_WIDTH);
    localparam int unsigned Lsb = idx_lsb(PHASE_WIDTH, ADDR_WIDTH);

    logic [1:0]            quad;
    logic [ADDR_WIDTH-1:0] idx;

    assign quad = phase_i[PHASE_WIDTH-1 -: 2];
    assign idx  = phase_i[Msb:Lsb];

    // Fractional phase bits only matter to the accumulator, not the address.
    if (Lsb > 0) begin : g_frac
        logic unused_frac;
        assign unused_frac = ^phase_i[Lsb-1:0];
    end

    // Odd quadrants walk the table backwards; the upper half-wave is negated.
    always_comb begin
        addr_o   = idx;
        negate_o = 1'b0;
        unique case (quad)
            Q0: begin
                addr_o   = idx;
                negate_o = 1'b0;
            end
            Q1: begin
                addr_o   = ~idx;
                negate_o = 1'b0;
            end
            Q2: begin
                addr_o   = idx;
                negate_o = 1'b1;
            end
            Q3: begin
                addr_o   = ~idx;
                negate_o = 1'b1;
            end
            default: begin
                addr_o   = idx;
                negate_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sin_dds_ctrl.sv
// DDS sequencer around an external quarter-wave sin_table ROM. Keeps a phase
// accumulator and frequency word, issues one table read per sample and
// delivers samples on a valid/ready stream.
// Build option SIN_DDS_FULL_WAVE_EN: enables quadrant folding and signed
// full-wave reconstruction; without it the table is swept directly.
module sin_dds_ctrl
    import sin_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DefDataWidth,
    parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
    parameter int unsigned PHASE_WIDTH = DefPhaseWidth
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_i,
    input  logic [PHASE_WIDTH-1:0] freq_i,
    input  logic                   freq_load_i,
    input  logic                   phase_clr_i,
    output logic [ADDR_WIDTH-1:0]  tbl_addr_o,
    output logic                   tbl_rd_o,
    input  logic [DATA_WIDTH-1:0]  tbl_dout_i,
    output logic [DATA_WIDTH:0]    sample_o,
    output logic                   sample_valid_o,
    input  logic                   sample_ready_i,
    output logic                   busy_o
);

    dds_state_e             state_q;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [PHASE_WIDTH-1:0] freq_q;
    logic [ADDR_WIDTH-1:0]  tbl_addr_q;
    logic                   tbl_rd_q;
    logic [DATA_WIDTH:0]    sample_q, sample_d;
    logic                   sample_valid_q;
    logic                   busy_q;
    logic [ADDR_WIDTH-1:0]  issue_addr;
    logic                   handshake;
    logic                   start_issue;

    assign handshake   = (state_q == StPresent) && sample_ready_i;
    assign start_issue = en_i && ((state_q == StIdle) || handshake);

    // Next phase: clear beats the handshake increment; wrap is modulo 2^PW.
    always_comb begin
        phase_d = phase_q;
        if (phase_clr_i) begin
            phase_d = '0;
        end else if (handshake) begin
            phase_d = phase_q + freq_q;
        end
    end

`ifdef SIN_DDS_FULL_WAVE_EN
    logic issue_neg;
    logic neg_q;

    // Address is folded from the phase the new sample will use.
    sin_quad_fold #(
        .PHASE_WIDTH (PHASE_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_fold (
        .phase_i  (phase_d),
        .addr_o   (issue_addr),
        .negate_o (issue_neg)
    );

    // Quadrant sign travels with the in-flight sample, captured at issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else if (start_issue) begin
            neg_q <= issue_neg;
        end
    end

    // Two's-complement rebuild; a zero magnitude negates to zero.
    always_comb begin
        sample_d = {1'b0, tbl_dout_i};
        if (neg_q) begin
            sample_d = -{1'b0, tbl_dout_i};
        end
    end
`else
    // Quarter-wave sweep: top phase bits address the table directly.
    assign issue_addr = phase_d[PHASE_WIDTH-1 -: ADDR_WIDTH];

    // Unsigned magnitude, zero-extended.
    always_comb begin
        sample_d = {1'b0, tbl_dout_i};
    end
`endif

    // Phase accumulator and frequency word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            freq_q  <= '0;
        end else begin
            phase_q <= phase_d;
            if (freq_load_i) begin
                freq_q <= freq_i;
            end
        end
    end

    // Sequencer FSM with registered table strobe, sample and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            tbl_addr_q     <= '0;
            tbl_rd_q       <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            tbl_rd_q <= 1'b0;
            if (start_issue) begin
                tbl_addr_q <= issue_addr;
                tbl_rd_q   <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (en_i) begin
                        state_q <= StIssue;
                        busy_q  <= 1'b1;
                    end
                end
                StIssue: begin
                    state_q <= StCapture;
                end
                StCapture: begin
                    state_q        <= StPresent;
                    sample_q       <= sample_d;
                    sample_valid_q <= 1'b1;
                end
                StPresent: begin
                    if (sample_ready_i) begin
                        sample_valid_q <= 1'b0;
                        if (en_i) begin
                            state_q <= StIssue;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tbl_addr_o     = tbl_addr_q;
    assign tbl_rd_o       = tbl_rd_q;
    assign sample_o       = sample_q;
    assign sample_valid_o = sample_valid_q;
    assign busy_o         = busy_q;

endmodule
